// File: rtl/core_seq_pkg.sv
// Shared opcode, state and trap definitions for the
// multi-cycle RV32I sequencer.
package core_seq_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [1:0] TRAP_NONE     = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL  = 2'd1;
  localparam logic [1:0] TRAP_MISALIGN = 2'd2;

endpackage

// File: rtl/core_seq.sv
// Multi-cycle sequencer: owns PC, IR and instret, and
// steps fetch/decode/execute/memory/writeback one at a time.
module core_seq
  import core_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic            dec_en,
  output logic            exec_en,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            wb_en,
  output logic            halted,
  output logic [1:0]      trap_cause,
  output logic [31:0]     instret
);

  state_t state;

  logic [6:0]      opcode;
  logic            is_mem;
  logic            writes_rd;
  logic [XLEN-1:0] next_pc;
  logic            misalign;
  logic            wb_q;

  function automatic logic legal_op(input logic [6:0] op);
    case (op)
      OPCODE_OP, OPCODE_OP_IMM, OPCODE_LOAD,
      OPCODE_STORE, OPCODE_BRANCH, OPCODE_JAL,
      OPCODE_JALR, OPCODE_LUI, OPCODE_AUIPC:
        legal_op = 1'b1;
      default:
        legal_op = 1'b0;
    endcase
  endfunction

  assign opcode = instr[6:0];
  assign is_mem = (opcode == OPCODE_LOAD) ||
                  (opcode == OPCODE_STORE);
  assign writes_rd = (opcode != OPCODE_STORE) &&
                     (opcode != OPCODE_BRANCH) &&
                     (instr[11:7] != 5'd0);

  assign next_pc = branch_taken ? branch_target
                                : pc + XLEN'(4);
  assign misalign = (next_pc[1:0] != 2'b00);

  // a faulting instruction must not write back
  assign wb_en = wb_q & ~misalign;

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      instr      <= '0;
      instret    <= '0;
      halted     <= 1'b0;
      trap_cause <= TRAP_NONE;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dec_en     <= 1'b0;
      exec_en    <= 1'b0;
      wb_q       <= 1'b0;
    end else begin
      dec_en  <= 1'b0;
      exec_en <= 1'b0;
      wb_q    <= 1'b0;
      unique case (state)
        S_FETCH: begin
          if (imem_req && imem_ack) begin
            instr    <= imem_rdata;
            imem_req <= 1'b0;
            dec_en   <= 1'b1;
            state    <= S_DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          if (legal_op(opcode)) begin
            exec_en <= 1'b1;
            state   <= S_EXECUTE;
          end else begin
            halted     <= 1'b1;
            trap_cause <= TRAP_ILLEGAL;
            state      <= S_HALT;
          end
        end
        S_EXECUTE: begin
          if (is_mem) begin
            dmem_req <= 1'b1;
            dmem_we  <= (opcode == OPCODE_STORE);
            state    <= S_MEMORY;
          end else begin
            wb_q  <= writes_rd;
            state <= S_WRITEBACK;
          end
        end
        S_MEMORY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            wb_q     <= writes_rd;
            state    <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          if (misalign) begin
            halted     <= 1'b1;
            trap_cause <= TRAP_MISALIGN;
            state      <= S_HALT;
          end else begin
            pc       <= next_pc;
            instret  <= instret + 32'd1;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          halted <= 1'b1;
          state  <= S_HALT;
        end
      endcase
    end
  end

endmodule
